// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory-controller port between instruction fetch and data access, instruction starvation bounded.
// Request to ready takes 2 cycles plus controller latency; requesters hold their request until their one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [24:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_oplen,
    input  logic        d_unsigned,
    input  logic [24:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        m_enable,
    output logic        m_rw,
    output logic [1:0]  m_oplen,
    output logic        m_unsigned,
    output logic [24:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_valid,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]      TO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [31:0]     TO_PATTERN = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic          m_enable_q, m_enable_d;
    logic          m_rw_q, m_rw_d;
    logic [1:0]    m_oplen_q, m_oplen_d;
    logic          m_unsigned_q, m_unsigned_d;
    logic [24:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          terr_q, terr_d;

    logic          data_wins;
    logic          finish;
    logic          expired;

    // Data has priority unless instruction fetch has already waited out STARVE_LIMIT data grants.
    assign data_wins = d_req && !(i_req && (starve_q == STARVE_MAX));
    assign expired   = !m_valid && (to_cnt_q == TO_LAST);
    assign finish    = m_valid || expired;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        to_cnt_d     = to_cnt_q;
        m_enable_d   = m_enable_q;
        m_rw_d       = m_rw_q;
        m_oplen_d    = m_oplen_q;
        m_unsigned_d = m_unsigned_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        terr_d       = terr_q;

        case (state_q)
            IDLE: begin
                if (data_wins) begin
                    state_d      = GNT_D;
                    m_enable_d   = 1'b1;
                    m_rw_d       = d_rw;
                    m_oplen_d    = d_oplen;
                    m_unsigned_d = d_unsigned;
                    m_addr_d     = d_addr;
                    m_wdata_d    = d_wdata;
                    to_cnt_d     = 8'd0;
                    if (i_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (i_req) begin
                    state_d      = GNT_I;
                    m_enable_d   = 1'b1;
                    m_rw_d       = 1'b0;
                    m_oplen_d    = 2'b11;
                    m_unsigned_d = 1'b1;
                    m_addr_d     = i_addr;
                    m_wdata_d    = 32'd0;
                    to_cnt_d     = 8'd0;
                    starve_d     = '0;
                end
            end
            GNT_D: begin
                if (finish) begin
                    state_d    = DONE;
                    m_enable_d = 1'b0;
                    d_ready_d  = 1'b1;
                    if (expired) begin
                        terr_d    = 1'b1;
                        d_rdata_d = TO_PATTERN;
                    end else if (!m_rw_q) begin
                        d_rdata_d = m_rdata;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            GNT_I: begin
                if (finish) begin
                    state_d    = DONE;
                    m_enable_d = 1'b0;
                    i_ready_d  = 1'b1;
                    if (expired) begin
                        terr_d    = 1'b1;
                        i_rdata_d = TO_PATTERN;
                    end else begin
                        i_rdata_d = m_rdata;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            DONE: begin
                // The ready pulse is visible this cycle; a request still held now is the one just served.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            to_cnt_q     <= 8'd0;
            m_enable_q   <= 1'b0;
            m_rw_q       <= 1'b0;
            m_oplen_q    <= 2'b00;
            m_unsigned_q <= 1'b0;
            m_addr_q     <= 25'd0;
            m_wdata_q    <= 32'd0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            to_cnt_q     <= to_cnt_d;
            m_enable_q   <= m_enable_d;
            m_rw_q       <= m_rw_d;
            m_oplen_q    <= m_oplen_d;
            m_unsigned_q <= m_unsigned_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            terr_q       <= terr_d;
        end
    end

    assign i_ready     = i_ready_q;
    assign i_rdata     = i_rdata_q;
    assign d_ready     = d_ready_q;
    assign d_rdata     = d_rdata_q;
    assign m_enable    = m_enable_q;
    assign m_rw        = m_rw_q;
    assign m_oplen     = m_oplen_q;
    assign m_unsigned  = m_unsigned_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [24:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_oplen;
    logic        d_unsigned;
    logic [24:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_enable;
    logic        m_rw;
    logic [1:0]  m_oplen;
    logic        m_unsigned;
    logic [24:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_valid;
    logic [31:0] m_rdata;
    logic        busy;
    logic        timeout_err;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_oplen(d_oplen), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .m_enable(m_enable), .m_rw(m_rw), .m_oplen(m_oplen), .m_unsigned(m_unsigned),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_valid(m_valid), .m_rdata(m_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    int          owner;      // 0 none, 1 data, 2 instr
    bit          in_done;
    int          waited;
    int          starve;
    bit          tmo;
    bit          e_men, e_rw, e_uns, e_ir, e_dr, e_terr;
    logic [1:0]  e_op;
    logic [24:0] e_addr;
    logic [31:0] e_wd, e_ird, e_drd;

    always @(posedge clk) begin
        if (rst) begin
            owner = 0; in_done = 0; waited = 0; starve = 0;
            e_men = 0; e_rw = 0; e_uns = 0; e_op = 2'b00; e_addr = '0; e_wd = '0;
            e_ir = 0; e_dr = 0; e_ird = '0; e_drd = '0; e_terr = 0;
        end else begin
            e_ir = 0;
            e_dr = 0;
            if (in_done) begin
                in_done = 0;
            end else if (owner != 0) begin
                waited++;
                if (m_valid || waited == TIMEOUT) begin
                    tmo     = !m_valid;
                    e_men   = 0;
                    in_done = 1;
                    if (tmo) e_terr = 1;
                    if (owner == 1) begin
                        e_dr = 1;
                        if (tmo) e_drd = 32'hDEADBEEF;
                        else if (!e_rw) e_drd = m_rdata;
                    end else begin
                        e_ir  = 1;
                        e_ird = tmo ? 32'hDEADBEEF : m_rdata;
                    end
                    owner = 0;
                end
            end else if (d_req && !(i_req && starve == STARVE_LIMIT)) begin
                owner = 1; waited = 0; e_men = 1;
                e_rw = d_rw; e_op = d_oplen; e_uns = d_unsigned; e_addr = d_addr; e_wd = d_wdata;
                if (i_req && starve < STARVE_LIMIT) starve++;
            end else if (i_req) begin
                owner = 2; waited = 0; e_men = 1;
                e_rw = 0; e_op = 2'b11; e_uns = 1; e_addr = i_addr; e_wd = '0;
                starve = 0;
            end
        end
    end

    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_enable",    32'(m_enable),    32'(e_men));
            chk("m_rw",        32'(m_rw),        32'(e_rw));
            chk("m_oplen",     32'(m_oplen),     32'(e_op));
            chk("m_unsigned",  32'(m_unsigned),  32'(e_uns));
            chk("m_addr",      32'(m_addr),      32'(e_addr));
            chk("m_wdata",     m_wdata,          e_wd);
            chk("i_ready",     32'(i_ready),     32'(e_ir));
            chk("d_ready",     32'(d_ready),     32'(e_dr));
            chk("i_rdata",     i_rdata,          e_ird);
            chk("d_rdata",     d_rdata,          e_drd);
            chk("busy",        32'(busy),        32'(owner != 0 || in_done));
            chk("timeout_err", 32'(timeout_err), 32'(e_terr));
            chk("ready_excl",  32'(i_ready & d_ready), 32'd0);
        end
    end

    // ---------------- requesters and controller ----------------
    int          ctrl_lat = 0;   // enable cycle on which m_valid fires; 0 = never
    logic [31:0] ctrl_data = '0;
    int          en_cnt = 0;
    int          en_max = 0;
    bit          inject = 0;
    bit          d_keep = 0;
    int          seq[$];         // 1 = d_ready seen, 2 = i_ready seen

    task automatic tick();
        @(negedge clk);
        if (i_ready) begin seq.push_back(2); i_req = 1'b0; end
        if (d_ready) begin seq.push_back(1); if (!d_keep) d_req = 1'b0; end
        if (m_enable) en_cnt++; else en_cnt = 0;
        if (en_cnt > en_max) en_max = en_cnt;
        m_valid = inject || (m_enable && ctrl_lat != 0 && en_cnt == ctrl_lat);
        m_rdata = ctrl_data;
        inject  = 0;
    endtask

    task automatic run_until(input int n_ready, input int budget, output int ticks);
        ticks = 0;
        while (seq.size() < n_ready && ticks < budget) begin
            tick();
            ticks++;
        end
        chk("ready_count", seq.size(), n_ready);
    endtask

    task automatic set_data(input bit rw, input logic [1:0] op, input bit uns,
                            input logic [24:0] a, input logic [31:0] wd);
        d_rw = rw; d_oplen = op; d_unsigned = uns; d_addr = a; d_wdata = wd; d_req = 1'b1;
    endtask

    int k;
    int exp_seq[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    initial begin
        rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_rw = 0; d_oplen = 0;
        d_unsigned = 0; d_addr = '0; d_wdata = '0; m_valid = 0; m_rdata = '0;
        tick(); tick();
        chk_on = 1;
        rst = 1'b0;
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_m_enable", 32'(m_enable),    32'd0);
        chk("rst_terr",     32'(timeout_err), 32'd0);
        tick();

        // single instruction fetch, controller answers on the 4th enable cycle
        seq.delete(); ctrl_lat = 4; ctrl_data = 32'h00100093;
        i_addr = 25'h10; i_req = 1'b1;
        run_until(1, 20, k);
        chk("t1_latency", k, 5);
        chk("t1_who",     seq[0], 2);
        chk("t1_rdata",   i_rdata, 32'h00100093);
        chk("t1_addr",    32'(m_addr), 32'h10);
        tick();
        chk("t1_busy_after", 32'(busy), 32'd0);

        // simultaneous requests: data write first, then instr
        seq.delete(); ctrl_lat = 1; ctrl_data = 32'h11112222;
        set_data(1'b1, 2'b00, 1'b0, 25'h40, 32'hAB);
        i_addr = 25'h20; i_req = 1'b1;
        tick();
        chk("t2_m_rw",    32'(m_rw),    32'd1);
        chk("t2_m_oplen", 32'(m_oplen), 32'd0);
        chk("t2_m_wdata", m_wdata,      32'hAB);
        chk("t2_m_addr",  32'(m_addr),  32'h40);
        run_until(2, 20, k);
        chk("t2_first",  seq[0], 1);
        chk("t2_second", seq[1], 2);
        chk("t2_d_rdata_kept", d_rdata, 32'd0);
        chk("t2_i_rdata", i_rdata, 32'h11112222);
        tick();

        // data half-word load
        seq.delete(); ctrl_lat = 2; ctrl_data = 32'hCAFEF00D;
        set_data(1'b0, 2'b01, 1'b1, 25'h123, 32'h0);
        run_until(1, 20, k);
        chk("t3_d_rdata", d_rdata, 32'hCAFEF00D);
        tick();

        // starvation: data held continuously, instr raised twice
        seq.delete(); ctrl_lat = 1; ctrl_data = 32'h0; d_keep = 1;
        set_data(1'b1, 2'b00, 1'b0, 25'h80, 32'h55);
        i_addr = 25'h30; i_req = 1'b1;
        run_until(5, 100, k);
        i_req = 1'b1;
        run_until(10, 100, k);
        d_req = 1'b0; d_keep = 0;
        for (int j = 0; j < 10; j++) chk("t4_grant_order", seq[j], exp_seq[j]);
        tick(); tick();

        // timeout: controller never answers
        seq.delete(); ctrl_lat = 0; en_max = 0;
        set_data(1'b0, 2'b11, 1'b0, 25'h200, 32'h0);
        run_until(1, 400, k);
        chk("t5_enable_cycles", en_max, TIMEOUT);
        chk("t5_m_enable",  32'(m_enable),    32'd0);
        chk("t5_terr",      32'(timeout_err), 32'd1);
        chk("t5_d_rdata",   d_rdata,          32'hDEADBEEF);
        tick();

        // reset in the middle of a data grant, stray m_valid afterwards
        seq.delete(); ctrl_lat = 0; ctrl_data = 32'h12345678;
        set_data(1'b0, 2'b11, 1'b0, 25'h55, 32'h0);
        tick();
        chk("t6_enabled", 32'(m_enable), 32'd1);
        rst = 1'b1; d_req = 1'b0; inject = 1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("t6_no_ready", seq.size(), 0);
        chk("t6_busy",     32'(busy),        32'd0);
        chk("t6_m_enable", 32'(m_enable),    32'd0);
        chk("t6_terr",     32'(timeout_err), 32'd0);
        chk("t6_d_rdata",  d_rdata,          32'd0);
        chk("t6_m_addr",   32'(m_addr),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while an instr request waits.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for m_valid per transaction (8-bit counter).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have the following ports, in this order:
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- i_req  in  1  instr fetch request, held until i_ready.
- i_addr  in  25  instr byte address.
- i_ready  out  1  one-cycle completion pulse.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request, held until d_ready.
- d_rw  in  1  1 = write.
- d_oplen  in  2  00 = byte, 01 = half, 10 = 3-byte, 11 = word.
- d_unsigned  in  1  zero-extend on load.
- d_addr  in  25  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle completion pulse.
- d_rdata  out  32  load result.
- m_enable  out  1  request to the memory controller.
- m_rw, m_oplen, m_unsigned, m_addr, m_wdata  out  1/2/1/25/32  forwarded command.
- m_valid  in  1  one-cycle controller completion.
- m_rdata  in  32  controller read data.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-005 SHALL implement states IDLE, GNT_D, GNT_I, DONE.
REQ-006 In IDLE, with d_req only: SHALL go to GNT_D; with i_req only: SHALL go to GNT_I; with neither: SHALL stay in IDLE.
REQ-007 In IDLE with both requests: SHALL grant data unless starve_cnt == STARVE_LIMIT, in which case it SHALL grant instr.
REQ-008 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on a data grant while i_req is high, and SHALL clear it on any instr grant.
REQ-009 On grant, SHALL register the command into the m_* outputs at the same edge; m_enable SHALL be 1 from the following cycle.
REQ-010 In GNT_I, SHALL drive m_rw = 0, m_oplen = 11, m_unsigned = 1, and m_wdata = 0.
REQ-011 SHALL hold all m_* outputs stable while m_enable = 1.
REQ-012 On m_valid in GNT_x (cycle n): SHALL drop m_enable at the edge, go to DONE, and in cycle n+1 pulse x_ready = 1 for exactly one cycle.
REQ-013 On a load completion, SHALL register m_rdata into x_rdata at the same edge as the ready pulse; a write SHALL leave d_rdata unchanged.
REQ-014 DONE SHALL last one cycle, grant nothing, and return to IDLE; a request still high during DONE SHALL be ignored.
REQ-015 Minimum request-to-ready latency SHALL be 2 cycles plus controller latency.
REQ-016 SHALL ignore m_valid in IDLE or DONE.
REQ-017 SHALL count cycles with m_enable = 1 in GNT_x; on reaching TIMEOUT without m_valid, SHALL drop m_enable, set timeout_err, drive x_rdata = 32'hDEADBEEF, and go to DONE (ready still pulses).
REQ-018 SHALL never pulse i_ready and d_ready in the same cycle.
REQ-019 SHALL never assert a ready pulse for a requester that was not granted.

Reset
REQ-020 On rst, SHALL go to IDLE and set m_enable = 0, i_ready = 0, d_ready = 0, busy = 0, timeout_err = 0, starve_cnt = 0, timeout counter = 0, and i_rdata = d_rdata = m_addr = m_wdata = 0.
REQ-021 Reset asserted mid-transaction SHALL abandon it with no ready pulse; an m_valid arriving after reset SHALL be ignored.

Verification
REQ-022 Single instr: i_req, i_addr = 0x10; controller returns m_valid with m_rdata = 0x00100093 three cycles after m_enable -> i_ready one cycle, i_rdata = 0x00100093, busy low after DONE.
REQ-023 Simultaneous requests: d_req (write 0xAB, oplen 00, addr 0x40) and i_req -> data is granted first with m_rw = 1, m_oplen = 00, m_wdata = 0xAB; instr is granted after DONE.
REQ-024 Starvation: d_req held continuously with i_req high -> exactly 4 data grants, then 1 instr grant, then starve_cnt = 0.
REQ-025 Timeout: controller never asserts m_valid -> after 255 enable cycles, m_enable = 0, timeout_err = 1, d_ready pulses with d_rdata = 0xDEADBEEF.
REQ-026 Reset mid-GNT_D, with m_valid one cycle later -> no d_ready pulse, state IDLE, all outputs at reset values.
